// File: rtl/fetch_unit.sv
// Byte prefetch queue between program memory (1-cycle read) and the decoder.
// Optional FETCH_BYPASS_EN forwards a response straight to the decoder when the queue is empty.
module fetch_unit #(
  parameter int              ADDR_W   = 16,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         resetN,
  output logic [ADDR_W-1:0]            memAddr,
  output logic                         memStrobe,
  input  logic [7:0]                   memDataRead,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirectAddr,
  output logic                         byteValid,
  output logic [7:0]                   byteData,
  output logic [ADDR_W-1:0]            byteAddr,
  input  logic                         byteReady,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [7:0]        dataQ [DEPTH];
  logic [ADDR_W-1:0] addrQ [DEPTH];
  logic [PTR_W-1:0]  headPtr, tailPtr;
  logic [ADDR_W-1:0] fetchPc, inFlightAddr;
  logic              inFlight;
  logic              rspValid, bypassHit, qEmpty, push, pop;

  assign qEmpty   = (count == '0);
  // A response landing in a redirect cycle belongs to the abandoned stream.
  assign rspValid = inFlight && !redirect;

`ifdef FETCH_BYPASS_EN
  assign bypassHit = rspValid && qEmpty;
`else
  assign bypassHit = 1'b0;
`endif

  always_comb begin
    memStrobe = 1'b0;
    memAddr   = redirect ? redirectAddr : fetchPc;
    if (resetN)
      memStrobe = redirect || ((int'(count) + int'(inFlight)) < DEPTH);
  end

  always_comb begin
    byteValid = resetN && !redirect && (!qEmpty || bypassHit);
    byteData  = dataQ[headPtr];
    byteAddr  = addrQ[headPtr];
    if (qEmpty) begin
      byteData = memDataRead;
      byteAddr = inFlightAddr;
    end
  end

  // A bypassed byte taken by the decoder this cycle never enters the queue.
  assign pop  = byteValid && byteReady && !qEmpty;
  assign push = resetN && rspValid && !(bypassHit && byteReady);

  always_ff @(posedge clk) begin
    if (push) begin
      dataQ[tailPtr] <= memDataRead;
      addrQ[tailPtr] <= inFlightAddr;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      fetchPc      <= RESET_PC;
      inFlight     <= 1'b0;
      inFlightAddr <= RESET_PC;
      headPtr      <= '0;
      tailPtr      <= '0;
      count        <= '0;
    end else begin
      inFlight     <= memStrobe;
      inFlightAddr <= memAddr;
      if (memStrobe)
        fetchPc <= memAddr + ADDR_W'(1);
      if (redirect) begin
        headPtr <= '0;
        tailPtr <= '0;
        count   <= '0;
      end else begin
        if (push) tailPtr <= tailPtr + PTR_W'(1);
        if (pop)  headPtr <= headPtr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected address stream queued per fetch segment, checked on delivery.
module tb_fetch_unit;
  localparam int AW = 16;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          resetN, redirect, byteReady;
  logic [AW-1:0] redirectAddr, memAddr, byteAddr;
  logic          memStrobe, byteValid;
  logic [7:0]    memDataRead, byteData;
  logic [2:0]    count;

  logic          rst2N, stb2, vld2;
  logic [AW-1:0] addr2, bAddr2;
  logic [7:0]    rd2, bData2;
  logic [2:0]    cnt2;

  int nChk = 0, nErr = 0, nStb = 0, nAcc = 0;
  logic [AW-1:0] expQ[$];
  logic [AW-1:0] wrapQ[$];
  logic [7:0]    wrapD[$];

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(AW), .DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .resetN(resetN), .memAddr(memAddr), .memStrobe(memStrobe),
    .memDataRead(memDataRead), .redirect(redirect), .redirectAddr(redirectAddr),
    .byteValid(byteValid), .byteData(byteData), .byteAddr(byteAddr),
    .byteReady(byteReady), .count(count));

  fetch_unit #(.ADDR_W(AW), .DEPTH(4), .RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .resetN(rst2N), .memAddr(addr2), .memStrobe(stb2),
    .memDataRead(rd2), .redirect(1'b0), .redirectAddr(16'h0000),
    .byteValid(vld2), .byteData(bData2), .byteAddr(bAddr2),
    .byteReady(1'b1), .count(cnt2));

  function automatic logic [7:0] memByte(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic startSeg(input logic [AW-1:0] base);
    expQ.delete();
    for (int i = 0; i < 64; i++) expQ.push_back(base + AW'(i));
  endtask

  // Memory models: data only valid the cycle after a strobe, garbage otherwise.
  always @(posedge clk) begin
    memDataRead <= memStrobe ? memByte(memAddr) : 8'($urandom);
    rd2         <= stb2 ? memByte(addr2) : 8'($urandom);
  end

  always @(negedge clk) begin
    if (memStrobe) nStb++;
    if (resetN && byteValid) begin
      if (expQ.size() == 0) chk("sb_empty", 1, 0);
      else begin
        chk("sb_addr", 32'(byteAddr), 32'(expQ[0]));
        chk("sb_data", 32'(byteData), 32'(memByte(expQ[0])));
        if (byteReady) begin
          void'(expQ.pop_front());
          nAcc++;
        end
      end
    end
    if (rst2N && vld2 && wrapQ.size() < 8) begin
      wrapQ.push_back(bAddr2);
      wrapD.push_back(bData2);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitValid(input string tag, input logic [AW-1:0] expAddr);
    int n = 0;
    while (!byteValid && n < 10) begin @(negedge clk); n++; end
    if (!byteValid) chk({tag, "_timeout"}, 0, 1);
    else chk(tag, 32'(byteAddr), 32'(expAddr));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1);
  end

  initial begin
    rst2N = 1'b0;
    cyc(3);
    rst2N = 1'b1;
  end

  initial begin
    int lat, a0, s0;
    resetN = 1'b0; redirect = 1'b0; redirectAddr = '0; byteReady = 1'b1;
    cyc(2);
    @(negedge clk);
    chk("rst_stb", 32'(memStrobe), 0);
    chk("rst_vld", 32'(byteValid), 0);
    chk("rst_cnt", 32'(count), 0);

    // reset release, streaming
    cyc(1); resetN = 1'b1; startSeg(16'h0000);
    @(negedge clk);
    chk("rel_stb", 32'(memStrobe), 1);
    chk("rel_addr", 32'(memAddr), 0);
    lat = 0;
    while (!byteValid && lat < 8) begin @(negedge clk); lat++; end
    chk("latency", lat, LAT);
    cyc(1); a0 = nAcc;
    cyc(10);
    chk("tput", nAcc - a0, 10);

    // backpressure from a fresh reset
    resetN = 1'b0;
    cyc(1); resetN = 1'b1; byteReady = 1'b0; startSeg(16'h0000); s0 = nStb;
    cyc(10);
    chk("stall_stb", nStb - s0, 4);
    chk("stall_cnt", 32'(count), 4);
    byteReady = 1'b1; a0 = nAcc;
    cyc(12);
    chk("drain", nAcc - a0, 12);

    // redirect with 3 queued, 1 in flight
    byteReady = 1'b0; lat = 0;
    while (count != 3'd3 && lat < 20) begin cyc(1); lat++; end
    chk("fill3", 32'(count), 3);
    redirect = 1'b1; redirectAddr = 16'h0040; byteReady = 1'b1; startSeg(16'h0040);
    @(negedge clk);
    chk("rd_stb", 32'(memStrobe), 1);
    chk("rd_addr", 32'(memAddr), 32'h40);
    chk("rd_vld", 32'(byteValid), 0);
    cyc(1); redirect = 1'b0;
    waitValid("rd_first", 16'h0040);
    cyc(6);

    // back-to-back redirects
    redirect = 1'b1; redirectAddr = 16'h0010; startSeg(16'h0010);
    cyc(1); redirectAddr = 16'h0020; startSeg(16'h0020);
    cyc(1); redirect = 1'b0;
    waitValid("rr_first", 16'h0020);
    cyc(6);

    // one-cycle reset mid-stream with a response in flight
    resetN = 1'b0;
    @(negedge clk);
    chk("mid_stb", 32'(memStrobe), 0);
    chk("mid_vld", 32'(byteValid), 0);
    cyc(1); resetN = 1'b1; startSeg(16'h0000);
    @(negedge clk);
    chk("mid_cnt", 32'(count), 0);
    chk("mid_vld2", 32'(byteValid), 0);
    chk("mid_stb2", 32'(memStrobe), 1);
    chk("mid_addr", 32'(memAddr), 0);
    cyc(10);

    // address wrap on the second instance
    if (wrapQ.size() < 4) chk("wrap_n", wrapQ.size(), 4);
    else begin
      chk("wrap0", 32'(wrapQ[0]), 32'hFFFE);
      chk("wrap1", 32'(wrapQ[1]), 32'hFFFF);
      chk("wrap2", 32'(wrapQ[2]), 32'h0000);
      chk("wrap3", 32'(wrapQ[3]), 32'h0001);
      chk("wrapd0", 32'(wrapD[0]), 32'(memByte(16'hFFFE)));
      chk("wrapd3", 32'(wrapD[3]), 32'(memByte(16'h0001)));
    end

    $display("CHECKS %0d ERRORS %0d", nChk, nErr);
    $finish;
  end
endmodule
